// File: rtl/srio_pkg.sv
// Shared SRIO arbitration types: FSM state encoding and source indices.
// Pure declarations; no timing or flow-control behaviour of its own.
package srio_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_DB  = 2'd1,
        GNT_NWR = 2'd2
    } arb_state_t;

    localparam logic SRC_DB  = 1'b0;
    localparam logic SRC_NWR = 1'b1;

endpackage

// File: rtl/ireq_arbiter.sv
// Packet-level arbiter of doorbell/NWRITE streams onto one SRIO ireq stream; one idle cycle per grant, beats then pass through with zero latency.
// Back-pressure: ireq_tready_in reaches only the granted source; the loser sees tready 0 until the granted packet's tlast handshake.
module ireq_arbiter
    import srio_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int USER_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic                log_clk,
    input  logic                log_rst_n,

    input  logic                db_tvalid_in,
    input  logic                db_tlast_in,
    input  logic [DATA_W-1:0]   db_tdata_in,
    input  logic [DATA_W/8-1:0] db_tkeep_in,
    input  logic [USER_W-1:0]   db_tuser_in,
    output logic                db_tready_o,

    input  logic                nwr_tvalid_in,
    input  logic                nwr_tlast_in,
    input  logic [DATA_W-1:0]   nwr_tdata_in,
    input  logic [DATA_W/8-1:0] nwr_tkeep_in,
    input  logic [USER_W-1:0]   nwr_tuser_in,
    output logic                nwr_tready_o,

    output logic                ireq_tvalid_o,
    output logic                ireq_tlast_o,
    output logic [DATA_W-1:0]   ireq_tdata_o,
    output logic [DATA_W/8-1:0] ireq_tkeep_o,
    output logic [USER_W-1:0]   ireq_tuser_o,
    input  logic                ireq_tready_in,

    output logic [1:0]          arb_grant_o,
    output logic                arb_busy_o,
    output logic [15:0]         db_pkt_cnt_o,
    output logic [15:0]         nwr_pkt_cnt_o
);

    arb_state_t  state_q, state_d;
    logic        last_served_q, last_served_d;
    logic [15:0] db_cnt_q, nwr_cnt_q;
    logic        pkt_end;

    assign pkt_end = ireq_tvalid_o & ireq_tready_in & ireq_tlast_o;

    always_ff @(posedge log_clk or negedge log_rst_n) begin
        if (!log_rst_n) begin
            state_q       <= IDLE;
            last_served_q <= SRC_NWR;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
        end
    end

    // Doorbell takes a tie when fixed priority is set or NWRITE was served last.
    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        case (state_q)
            IDLE: begin
                if (db_tvalid_in && (!nwr_tvalid_in || (FIXED_PRIO != 0) ||
                                     (last_served_q == SRC_NWR))) begin
                    state_d       = GNT_DB;
                    last_served_d = SRC_DB;
                end else if (nwr_tvalid_in) begin
                    state_d       = GNT_NWR;
                    last_served_d = SRC_NWR;
                end
            end
            GNT_DB, GNT_NWR: begin
                if (pkt_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ireq_tvalid_o = 1'b0;
        ireq_tlast_o  = 1'b0;
        ireq_tdata_o  = '0;
        ireq_tkeep_o  = '0;
        ireq_tuser_o  = '0;
        db_tready_o   = 1'b0;
        nwr_tready_o  = 1'b0;
        case (state_q)
            GNT_DB: begin
                ireq_tvalid_o = db_tvalid_in;
                ireq_tlast_o  = db_tlast_in;
                ireq_tdata_o  = db_tdata_in;
                ireq_tkeep_o  = db_tkeep_in;
                ireq_tuser_o  = db_tuser_in;
                db_tready_o   = ireq_tready_in;
            end
            GNT_NWR: begin
                ireq_tvalid_o = nwr_tvalid_in;
                ireq_tlast_o  = nwr_tlast_in;
                ireq_tdata_o  = nwr_tdata_in;
                ireq_tkeep_o  = nwr_tkeep_in;
                ireq_tuser_o  = nwr_tuser_in;
                nwr_tready_o  = ireq_tready_in;
            end
            default: ;
        endcase
    end

    always_ff @(posedge log_clk or negedge log_rst_n) begin
        if (!log_rst_n) begin
            db_cnt_q  <= '0;
            nwr_cnt_q <= '0;
        end else if (pkt_end) begin
            if (state_q == GNT_DB)  db_cnt_q  <= db_cnt_q + 16'd1;
            if (state_q == GNT_NWR) nwr_cnt_q <= nwr_cnt_q + 16'd1;
        end
    end

    assign arb_grant_o   = {state_q == GNT_NWR, state_q == GNT_DB};
    assign arb_busy_o    = (state_q != IDLE);
    assign db_pkt_cnt_o  = db_cnt_q;
    assign nwr_pkt_cnt_o = nwr_cnt_q;

endmodule

// File: doc/ireq_arbiter.md
IREQ_ARBITER -- requirements
Module: ireq_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 64, ireq/source tdata width.
REQ-002 SHALL have parameter USER_W, default 32, tuser width.
REQ-003 SHALL have parameter FIXED_PRIO, default 0; 0 = round-robin, 1 = doorbell always wins.
REQ-004 SHALL have port log_clk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port log_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have ports db_tvalid_in/db_tlast_in  in  1, db_tdata_in  in  DATA_W, db_tkeep_in  in  DATA_W/8, db_tuser_in  in  USER_W, db_tready_o  out  1: doorbell source stream.
REQ-007 SHALL have ports nwr_tvalid_in/nwr_tlast_in  in  1, nwr_tdata_in  in  DATA_W, nwr_tkeep_in  in  DATA_W/8, nwr_tuser_in  in  USER_W, nwr_tready_o  out  1: NWRITE source stream.
REQ-008 SHALL have ports ireq_tvalid_o/ireq_tlast_o  out  1, ireq_tdata_o  out  DATA_W, ireq_tkeep_o  out  DATA_W/8, ireq_tuser_o  out  USER_W, ireq_tready_in  in  1: shared SRIO ireq stream.
REQ-009 SHALL have port arb_grant_o  out  2  one-hot grant, bit0 doorbell, bit1 NWRITE, 00 when idle.
REQ-010 SHALL have port arb_busy_o  out  1  high while any packet is granted.
REQ-011 SHALL have ports db_pkt_cnt_o, nwr_pkt_cnt_o  out  16  completed-packet counters.

Function
REQ-012 SHALL implement FSM states IDLE, GNT_DB, GNT_NWR.
REQ-013 IDLE: ireq_tvalid_o, ireq_tlast_o, ireq_tdata_o, ireq_tkeep_o, ireq_tuser_o, db_tready_o, nwr_tready_o SHALL all be 0.
REQ-014 IDLE -> GNT_x SHALL occur on the clock edge where source x tvalid_in is high and x wins arbitration; first beat may transfer the cycle after (one bubble cycle per packet).
REQ-015 In GNT_x, ireq outputs SHALL be combinational copies of source x; x_tready_o = ireq_tready_in; other source's tready_o = 0.
REQ-016 Grant SHALL be held until a beat with tvalid & tready & tlast on ireq; state then returns to IDLE on that edge.
REQ-017 Source deasserting tvalid mid-packet SHALL NOT release the grant; the other source waits.
REQ-018 Round-robin: 1-bit last_served register; with both tvalid high in IDLE, grant the source not last_served; single requester always wins.
REQ-019 FIXED_PRIO=1: both valid in IDLE -> doorbell wins; last_served still updated.
REQ-020 last_served SHALL update on the grant edge, not at packet end.
REQ-021 Packet counter x SHALL increment by 1 on each tlast handshake of granted source x; 16'hFFFF wraps to 16'h0000.
REQ-022 arb_grant_o and arb_busy_o SHALL be registered state decodes, no combinational path from inputs.
REQ-023 No data buffering; zero-latency pass-through of data beats; tready back-pressure honoured per AXI4-Stream (data/valid held by source).

Reset
REQ-024 On log_rst_n low: state = IDLE, last_served = NWRITE (so doorbell wins first tie), counters = 0, arb_grant_o = 00, arb_busy_o = 0, all stream outputs 0.
REQ-025 Reset asserted mid-packet SHALL abort the packet immediately; no resume after release.
REQ-026 Reset deassertion SHALL be synchronised externally; block uses log_rst_n directly in async sensitivity.

Structure
REQ-027 State enum (arb_state_t) and source index constants (SRC_DB=0, SRC_NWR=1) SHALL live in shared package srio_pkg.
REQ-028 Single module; no sub-module; the stream mux is inline.

Verification
REQ-029 Only db valid, 1-beat packet, tready=1 -> arb_grant_o=01 one cycle after tvalid, ireq_tvalid_o one cycle, db_pkt_cnt_o=1.
REQ-030 Both valid at reset exit, db 1 beat, nwr 4 beats -> db served first, then nwr; four nwr beats on ireq in order; counts 1/1.
REQ-031 Both continuously valid, 6 packets each -> strict alternation db,nwr,db,...; FIXED_PRIO=1 -> all db first.
REQ-032 nwr 4-beat packet, ireq_tready_in low 3 cycles at beat 2, db valid throughout -> nwr beats intact, db granted only after nwr tlast.
REQ-033 nwr_pkt_cnt_o preloaded by 65535 packets, one more -> reads 0.
REQ-034 log_rst_n low during beat 2 of nwr packet -> next cycle all outputs 0, grant 00, counters 0.
